pulse_burst_scheduler: RTL and testbench
========================================

# pulse_burst_scheduler

Shares one pulse-train engine between `NumCh` requesters, each with its own output line. It round-robin arbitrates burst requests and latches the winner's pulse count, half-period and start/end polarity. It then plays the burst on that channel's line and reports completion. It sits between software-facing control registers and the board-level pulse pins that the single-channel pulse generator drives today.

## Interface
- `NumCh`, 4: number of requesters/output lines (2..8)
- `MaxPulseCnt`, 15: largest accepted pulse count; `CntW = $clog2(MaxPulseCnt+1)`
- `HalfW`, 8: width of the half-period field, in clock cycles
- `GapCycles`, 2: idle cycles forced between consecutive bursts (0 allowed)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  NumCh  per-channel burst request
- `req_ready`  out  NumCh  one-hot grant; a handshake occurs when valid&ready
- `req_pulse_cnt`  in  NumCh×CntW  pulses per burst
- `req_half_cycles`  in  NumCh×HalfW  cycles per flip segment; 0 is treated as 1
- `req_spol`  in  NumCh  level at burst start
- `req_epol`  in  NumCh  level at burst end
- `pulse_o`  out  NumCh  per-channel pulse lines
- `done`  out  NumCh  one-cycle completion strobe, one-hot
- `busy`  out  1  high in RUN or GAP

## Operation
- FSM states: IDLE, RUN, GAP.
- **IDLE**
  - If any `req_valid` is high, grant exactly one channel `g` by round-robin: search starts at the channel after the last granted one.
  - After reset, channel 0 has highest priority.
  - `req_ready[g]` is high combinationally for that single cycle. That cycle is the handshake cycle T.
  - At T, latch cnt, H = max(half_cycles, 1), spol and epol. Compute F = 2·cnt + (spol^epol). Go to RUN.
- **RUN**
  - Lasts (F+1)·H cycles, split into F+1 segments of H cycles.
  - Segment 0 drives `pulse_o[g]` = spol. Each later segment inverts the line, so the last segment ends at epol.
  - Flip counter width is `$clog2(2*MaxPulseCnt+2)`. Cycle counter width is HalfW; it wraps to 0 at H-1.
  - `done[g]` is high in the last RUN cycle.
  - Then go to GAP, or straight to IDLE when GapCycles = 0.
- **GAP**: counts GapCycles, then goes to IDLE. No grants in RUN or GAP.
- Non-granted lines hold their last driven level. The granted line keeps epol after the burst.
- cnt = 0 with spol == epol: F = 0, so one segment at spol, then done.
- cnt > MaxPulseCnt cannot be represented (the field is CntW wide).
- `req_valid` dropping before its grant is legal and causes no effect. `req_valid` held after done re-requests a new burst; it competes normally.
- Request fields are sampled only at T. Changes during RUN are ignored.
- Reset mid-burst: next cycle state is IDLE, all `pulse_o` = 0, counters = 0, rr pointer = channel 0. No `done` is issued.

## Timing
- Reset values: `pulse_o` = 0, `done` = 0, `busy` = 0, `req_ready` = 0, state IDLE.
- `pulse_o[g]` = spol from T+1. Flip k (k = 1..F) is visible at T+1+k·H.
- `done[g]` is high at T+(F+1)·H. `busy` is high from T+1 through the end of GAP.
- Earliest next handshake is at T+(F+1)·H+GapCycles+1.
- All outputs except `req_ready` are registered.

## Configuration
- `PULSE_SCHED_ABORT_EN` defined:
  - Adds input `abort` (NumCh).
  - `abort[g]` high in RUN forces `pulse_o[g]` = epol on the next cycle. `done[g]` also pulses on that cycle, which is the final RUN cycle.
  - Then GAP proceeds normally.
  - `abort` on a non-active channel, or in IDLE/GAP, is ignored.
- Macro not defined: no `abort` port exists, and every burst runs to completion.

## Test plan
- Ch1, cnt=2, H=2, spol=0, epol=0, handshake at T:
  - Line 0 at T+1, 1 at T+3, 0 at T+5, 1 at T+7, 0 at T+9.
  - `done[1]` at T+10; `busy` low at T+13.
- All four `req_valid` held high after reset:
  - Grants occur in order 0,1,2,3,0.
  - Each `req_ready` is high for exactly one cycle and is one-hot.
- cnt=0, spol=1, epol=0, H=0:
  - F=1 and H is treated as 1.
  - Line 1 at T+1, 0 at T+2; `done` at T+2.
- Reset asserted while ch2 is mid-burst: next cycle all lines 0, no `done`, state IDLE. The next grant goes to ch0 if it is requesting.
- With `PULSE_SCHED_ABORT_EN` defined: ch0 with cnt=5, H=4, epol=1, abort at T+6. Line 1 and `done[0]` at T+7; `busy` low at T+10.
- `req_valid[3]` pulsed for one cycle while ch1 is busy: no grant to ch3, and ch3's line is unchanged.

Source files
------------

// File: rtl/pulse_burst_scheduler.sv
// pulse_burst_scheduler: round-robin shares one pulse-train engine between NumCh requesters.
// A granted burst plays F+1 segments of H cycles on the winner's line, starting at spol and
// ending at epol, then a GapCycles idle gap follows before the next grant.
// Optional feature: define PULSE_SCHED_ABORT_EN to add a per-channel abort input.
module pulse_burst_scheduler #(
  parameter int unsigned  NumCh       = 4,
  parameter int unsigned  MaxPulseCnt = 15,
  parameter int unsigned  HalfW       = 8,
  parameter int unsigned  GapCycles   = 2,
  localparam int unsigned CntW        = $clog2(MaxPulseCnt + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NumCh-1:0]       req_valid,
  output logic [NumCh-1:0]       req_ready,
  input  logic [NumCh*CntW-1:0]  req_pulse_cnt,
  input  logic [NumCh*HalfW-1:0] req_half_cycles,
  input  logic [NumCh-1:0]       req_spol,
  input  logic [NumCh-1:0]       req_epol,
`ifdef PULSE_SCHED_ABORT_EN
  input  logic [NumCh-1:0]       abort,
`endif
  output logic [NumCh-1:0]       pulse_o,
  output logic [NumCh-1:0]       done,
  output logic                   busy
);

  localparam int unsigned IdxW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned FlipW = $clog2(2 * MaxPulseCnt + 2);
  localparam int unsigned GapW  = (GapCycles < 2) ? 1 : $clog2(GapCycles);
  localparam logic [GapW-1:0] GapLast = GapW'((GapCycles == 0) ? 0 : GapCycles - 1);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  // With no gap configured a finished burst returns straight to IDLE.
  localparam state_e StAfterRun = (GapCycles == 0) ? StIdle : StGap;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ch_q, ch_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [HalfW-1:0]  h_q, h_d;
  logic [FlipW-1:0]  f_q, f_d;
  logic              epol_q, epol_d;
  logic [HalfW-1:0]  cyc_q, cyc_d;
  logic [FlipW-1:0]  flip_q, flip_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [NumCh-1:0]  pulse_q, pulse_d;
  logic [NumCh-1:0]  done_q, done_d;
  logic              busy_q;
`ifdef PULSE_SCHED_ABORT_EN
  logic              abort_q, abort_d;
`endif

  logic              gnt_vld;
  logic [IdxW-1:0]   gnt_idx;
  logic [CntW-1:0]   gnt_cnt;
  logic [HalfW-1:0]  gnt_half;
  logic              run_last;
  logic              seg_end;

  // Round-robin search beginning at the channel after the last grant.
  always_comb begin
    int unsigned     j;
    logic [IdxW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= NumCh) j = j - NumCh;
      jj = IdxW'(j);
      if (!gnt_vld && req_valid[jj]) begin
        gnt_vld = 1'b1;
        gnt_idx = jj;
      end
    end
  end

  assign gnt_cnt   = req_pulse_cnt[gnt_idx*CntW +: CntW];
  assign gnt_half  = req_half_cycles[gnt_idx*HalfW +: HalfW];
  assign req_ready = (state_q == StIdle && gnt_vld && !reset) ? (NumCh'(1) << gnt_idx) : '0;

  assign seg_end  = (cyc_q == h_q - HalfW'(1));
  assign run_last = seg_end && (flip_q == f_q);

  // Next-state, burst bookkeeping and registered-output next values.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    h_d     = h_q;
    f_d     = f_q;
    epol_d  = epol_q;
    cyc_d   = cyc_q;
    flip_d  = flip_q;
    gap_d   = gap_q;
    pulse_d = pulse_q;
    done_d  = '0;
`ifdef PULSE_SCHED_ABORT_EN
    abort_d = abort_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          ch_d             = gnt_idx;
          ptr_d            = (gnt_idx == IdxW'(NumCh - 1)) ? '0 : gnt_idx + IdxW'(1);
          h_d              = (gnt_half == '0) ? HalfW'(1) : gnt_half;
          f_d              = FlipW'({gnt_cnt, 1'b0})
                             + FlipW'(req_spol[gnt_idx] ^ req_epol[gnt_idx]);
          epol_d           = req_epol[gnt_idx];
          cyc_d            = '0;
          flip_d           = '0;
          pulse_d[gnt_idx] = req_spol[gnt_idx];
          state_d          = StRun;
        end
      end
      StRun: begin
`ifdef PULSE_SCHED_ABORT_EN
        if (abort_q) begin
          // The forced epol cycle was the final RUN cycle.
          abort_d = 1'b0;
          gap_d   = '0;
          state_d = StAfterRun;
        end else
`endif
        if (run_last) begin
          gap_d   = '0;
          state_d = StAfterRun;
`ifdef PULSE_SCHED_ABORT_EN
        end else if (abort[ch_q]) begin
          abort_d       = 1'b1;
          pulse_d[ch_q] = epol_q;
`endif
        end else if (seg_end) begin
          cyc_d         = '0;
          flip_d        = flip_q + FlipW'(1);
          pulse_d[ch_q] = ~pulse_q[ch_q];
        end else begin
          cyc_d = cyc_q + HalfW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
    // done is registered, so raise it when the upcoming cycle is the last RUN cycle.
`ifdef PULSE_SCHED_ABORT_EN
    if (state_d == StRun && (abort_d || ((flip_d == f_d) && (cyc_d == h_d - HalfW'(1))))) begin
      done_d[ch_d] = 1'b1;
    end
`else
    if (state_d == StRun && (flip_d == f_d) && (cyc_d == h_d - HalfW'(1))) begin
      done_d[ch_d] = 1'b1;
    end
`endif
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      ptr_q   <= '0;
      h_q     <= '0;
      f_q     <= '0;
      epol_q  <= 1'b0;
      cyc_q   <= '0;
      flip_q  <= '0;
      gap_q   <= '0;
      pulse_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifdef PULSE_SCHED_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      h_q     <= h_d;
      f_q     <= f_d;
      epol_q  <= epol_d;
      cyc_q   <= cyc_d;
      flip_q  <= flip_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      busy_q  <= (state_d != StIdle);
`ifdef PULSE_SCHED_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

  assign pulse_o = pulse_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed bench for pulse_burst_scheduler. Grants and completions are checked against a
// scoreboard: expected grants are queued when requests are driven, and each observed grant
// queues the expected completion channel and cycle.
module tb_pulse_burst_scheduler;

  localparam int NumCh = 4;
  localparam int MaxPulseCnt = 15;
  localparam int HalfW = 8;
  localparam int GapCycles = 2;
  localparam int CntW = $clog2(MaxPulseCnt + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NumCh-1:0]       req_valid;
  logic [NumCh-1:0]       req_ready;
  logic [NumCh*CntW-1:0]  req_pulse_cnt;
  logic [NumCh*HalfW-1:0] req_half_cycles;
  logic [NumCh-1:0]       req_spol;
  logic [NumCh-1:0]       req_epol;
  logic [NumCh-1:0]       pulse_o;
  logic [NumCh-1:0]       done;
  logic                   busy;
`ifdef PULSE_SCHED_ABORT_EN
  logic [NumCh-1:0]       abort;
`endif

  pulse_burst_scheduler #(
    .NumCh(NumCh), .MaxPulseCnt(MaxPulseCnt), .HalfW(HalfW), .GapCycles(GapCycles)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_pulse_cnt(req_pulse_cnt),
    .req_half_cycles(req_half_cycles),
    .req_spol(req_spol),
    .req_epol(req_epol),
`ifdef PULSE_SCHED_ABORT_EN
    .abort(abort),
`endif
    .pulse_o(pulse_o),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; int dur;} gexp_t;
  typedef struct {int ch; int cyc;} dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];

  int n_asserts = 0;
  int n_fail = 0;
  logic [NumCh-1:0] prev_rr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference burst length: (2*cnt + (spol^epol) + 1) segments of max(h,1) cycles.
  function automatic int dur_of(int cnt, int h, bit sp, bit ep);
    return (2 * cnt + int'(sp ^ ep) + 1) * ((h == 0) ? 1 : h);
  endfunction

  task automatic push_exp(int ch, int dur);
    gq.push_back('{ch: ch, dur: dur});
  endtask

  task automatic set_fields(int ch, int cnt, int h, bit sp, bit ep);
    req_pulse_cnt[ch*CntW +: CntW]     = CntW'(cnt);
    req_half_cycles[ch*HalfW +: HalfW] = HalfW'(h);
    req_spol[ch]                       = sp;
    req_epol[ch]                       = ep;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drive_at(int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_grant(int ch, output int t);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[ch] === 1'b1) break;
    end
    chk("grant_seen", 32'(req_ready[ch]), 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && dq.size() == 0) break;
    end
    chk("idle_reached", {31'd0, busy}, 0);
    chk("done_queue_drained", dq.size(), 0);
    tick();
  endtask

  // Grant monitor: one-hot, single-cycle, in scoreboard order.
  always @(negedge clk) begin : mon_grant
    gexp_t e;
    if (req_ready !== '0) begin
      chk("ready_onehot", $countones(req_ready), 1);
      chk("ready_single_cycle", 32'(prev_rr), 0);
      if (gq.size() == 0) begin
        chk("unexpected_grant", 32'(req_ready), 0);
      end else begin
        e = gq.pop_front();
        chk("grant_ch", 32'(req_ready), 32'(1) << e.ch);
        dq.push_back('{ch: e.ch, cyc: cyc + e.dur});
      end
    end
    prev_rr <= req_ready;
  end

  // Completion monitor: channel and cycle of each done strobe.
  always @(negedge clk) begin : mon_done
    dexp_t e;
    if (done !== '0) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'(done), 0);
      end else begin
        e = dq.pop_front();
        chk("done_ch", 32'(done), 32'(1) << e.ch);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, tp;
    reset           = 1'b1;
    req_valid       = '0;
    req_pulse_cnt   = '0;
    req_half_cycles = '0;
    req_spol        = '0;
    req_epol        = '0;
`ifdef PULSE_SCHED_ABORT_EN
    abort           = '0;
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pulse", 32'(pulse_o), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b0;

    // Ch1, cnt=2, H=2, spol=0, epol=0.
    set_fields(1, 2, 2, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    push_exp(1, dur_of(2, 2, 1'b0, 1'b0));
    wait_grant(1, t);
    tick();
    req_valid[1] = 1'b0;
    set_fields(1, 7, 5, 1'b1, 1'b1);  // must be ignored mid-burst
    wait_cyc(t + 1);  chk("t1_line_t1", 32'(pulse_o[1]), 0);
    chk("t1_busy_t1", {31'd0, busy}, 1);
    wait_cyc(t + 3);  chk("t1_line_t3", 32'(pulse_o[1]), 1);
    wait_cyc(t + 5);  chk("t1_line_t5", 32'(pulse_o[1]), 0);
    wait_cyc(t + 7);  chk("t1_line_t7", 32'(pulse_o[1]), 1);
    wait_cyc(t + 9);  chk("t1_line_t9", 32'(pulse_o[1]), 0);
    wait_cyc(t + 10); chk("t1_done_t10", 32'(done), 32'b0010);
    wait_cyc(t + 12); chk("t1_busy_t12", {31'd0, busy}, 1);
    wait_cyc(t + 13); chk("t1_busy_t13", {31'd0, busy}, 0);
    wait_idle();

    // Ch2, cnt=0, spol=1, epol=0, H=0 (treated as 1).
    set_fields(2, 0, 0, 1'b1, 1'b0);
    req_valid[2] = 1'b1;
    push_exp(2, dur_of(0, 0, 1'b1, 1'b0));
    wait_grant(2, t);
    tick();
    req_valid[2] = 1'b0;
    wait_cyc(t + 1); chk("h0_line_t1", 32'(pulse_o[2]), 1);
    wait_cyc(t + 2); chk("h0_line_t2", 32'(pulse_o[2]), 0);
    chk("h0_done_t2", 32'(done), 32'b0100);
    wait_cyc(t + 3); chk("h0_line_hold", 32'(pulse_o[2]), 0);
    wait_idle();

    // Ch3, cnt=0, spol=epol=1, H=3: single segment, line stays at epol.
    set_fields(3, 0, 3, 1'b1, 1'b1);
    req_valid[3] = 1'b1;
    push_exp(3, dur_of(0, 3, 1'b1, 1'b1));
    wait_grant(3, t);
    tick();
    req_valid[3] = 1'b0;
    wait_cyc(t + 1); chk("f0_line_t1", 32'(pulse_o[3]), 1);
    wait_cyc(t + 3); chk("f0_done_t3", 32'(done), 32'b1000);
    wait_cyc(t + 6); chk("f0_line_hold", 32'(pulse_o[3]), 1);
    wait_idle();

`ifdef PULSE_SCHED_ABORT_EN
    // Ch0, cnt=5, H=4, spol=1, epol=1, abort at T+6; abort on ch2 earlier is ignored.
    set_fields(0, 5, 4, 1'b1, 1'b1);
    req_valid[0] = 1'b1;
    push_exp(0, 7);
    wait_grant(0, t);
    tick();
    req_valid[0] = 1'b0;
    tick();
    abort[2] = 1'b1;
    tick();
    abort[2] = 1'b0;
    wait_cyc(t + 3); chk("ab_line_t3", 32'(pulse_o[0]), 1);
    drive_at(t + 6);
    abort[0] = 1'b1;
    wait_cyc(t + 6); chk("ab_line_t6", 32'(pulse_o[0]), 0);
    tick();
    abort[0] = 1'b0;
    wait_cyc(t + 7);  chk("ab_line_t7", 32'(pulse_o[0]), 1);
    chk("ab_done_t7", 32'(done), 32'b0001);
    wait_cyc(t + 9);  chk("ab_busy_t9", {31'd0, busy}, 1);
    wait_cyc(t + 10); chk("ab_busy_t10", {31'd0, busy}, 0);
    wait_idle();
`endif

    // Round robin from reset with all four requesting.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < NumCh; c++) set_fields(c, 0, 1, 1'b0, 1'b0);
    req_valid = '1;
    for (int k = 0; k < 5; k++) push_exp(k % NumCh, 1);
    wait_grant(0, tp);
    for (int k = 1; k < 5; k++) begin
      wait_grant(k % NumCh, t);
      chk("rr_spacing", t - tp, 1 + GapCycles + 1);
      tp = t;
    end
    tick();
    req_valid = '0;
    wait_idle();

    // Reset while ch2 is mid-burst; ch0 and ch3 request across the reset.
    set_fields(2, 5, 3, 1'b1, 1'b0);
    req_valid[2] = 1'b1;
    push_exp(2, dur_of(5, 3, 1'b1, 1'b0));
    wait_grant(2, t);
    tick();
    req_valid[2] = 1'b0;
    tick();
    reset = 1'b1;
    set_fields(0, 0, 1, 1'b0, 1'b0);
    set_fields(3, 0, 1, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    dq.delete();
    push_exp(0, 1);
    wait_cyc(t + 2); chk("mr_line_before", 32'(pulse_o[2]), 1);
    chk("mr_ready_in_reset", 32'(req_ready), 0);
    tick();
    reset = 1'b0;
    wait_cyc(t + 3); chk("mr_pulse_cleared", 32'(pulse_o), 0);
    chk("mr_no_done", 32'(done), 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_grant_ch0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_idle();

    // Ch3 pulses valid for one cycle while ch1 is busy: no grant, line unchanged.
    set_fields(1, 3, 2, 1'b0, 1'b1);
    req_valid[1] = 1'b1;
    push_exp(1, dur_of(3, 2, 1'b0, 1'b1));
    wait_grant(1, t);
    tick();
    req_valid[1] = 1'b0;
    drive_at(t + 3);
    set_fields(3, 1, 1, 1'b1, 1'b1);
    req_valid[3] = 1'b1;
    wait_cyc(t + 3); chk("bp_no_grant", 32'(req_ready), 0);
    chk("bp_line3", 32'(pulse_o[3]), 0);
    tick();
    req_valid[3] = 1'b0;
    wait_idle();
    repeat (5) tick();
    @(negedge clk);
    chk("bp_final_lines", 32'(pulse_o), 32'b0010);

    chk("grant_queue_drained", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
